// File: rtl/alu_cmd_issuer.sv
// Issues host commands to a registered 4-bit ALU and checks each result against an expected value.
// Results are buffered in order in a response FIFO; cmd_ready reserves a FIFO slot for every command in flight.
module alu_cmd_issuer #(
    parameter int RSP_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    output logic [1:0] alu_opcode,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    input  logic [4:0] alu_c,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [4:0] rsp_data,
    output logic [1:0] rsp_op,
    output logic       rsp_err,
    output logic       err_sticky,
    input  logic       err_clr,
    output logic       busy
);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [1:0]    op_q, op_d;
    logic [3:0]    a_q, a_d;
    logic [3:0]    b_q, b_d;
    logic          s1_q, s1_d;
    logic          s2_q, s2_d;
    logic [1:0]    op2_q, op2_d;
    logic [4:0]    exp2_q, exp2_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic [4:0]    mem_data [RSP_DEPTH];
    logic [1:0]    mem_op   [RSP_DEPTH];
    logic          mem_err  [RSP_DEPTH];

    logic          accept;
    logic          push;
    logic          pop;
    logic          mismatch;
    logic [4:0]    exp_s1;
    logic [CW:0]   occupancy;

    // Slots already promised = buffered entries plus both pipeline stages.
    assign occupancy = {1'b0, count_q} + (CW + 1)'(s1_q) + (CW + 1)'(s2_q);
    assign cmd_ready = occupancy < (CW + 1)'(RSP_DEPTH);
    assign accept    = cmd_valid && cmd_ready;
    assign push      = s2_q;
    assign pop       = rsp_valid && rsp_ready;
    assign mismatch  = alu_c != exp2_q;

    // Expected result derived from the operands currently driving the ALU.
    always_comb begin
        exp_s1 = '0;
        case (op_q)
            2'b00:   exp_s1 = {a_q[3], a_q} + {b_q[3], b_q};
            2'b01:   exp_s1 = {a_q[3], a_q} - {b_q[3], b_q};
            2'b10:   exp_s1 = ~{a_q[3], a_q};
            default: exp_s1 = {4'b0000, |b_q};
        endcase
    end

    always_comb begin
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        if (accept) begin
            op_d = cmd_op;
            a_d  = cmd_a;
            b_d  = cmd_b;
        end
        s1_d     = accept;
        s2_d     = s1_q;
        op2_d    = op2_q;
        exp2_d   = exp2_q;
        if (s1_q) begin
            op2_d  = op_q;
            exp2_d = exp_s1;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        // A mismatch landing in the same cycle as a clear must win.
        err_d    = err_q;
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (push && mismatch) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            op2_q    <= '0;
            exp2_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            op2_q    <= op2_d;
            exp2_q   <= exp2_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= alu_c;
            mem_op[wr_ptr_q]   <= op2_q;
            mem_err[wr_ptr_q]  <= mismatch;
        end
    end

    assign alu_opcode = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign rsp_valid  = count_q != '0;
    assign rsp_data   = rsp_valid ? mem_data[rd_ptr_q] : 5'b00000;
    assign rsp_op     = rsp_valid ? mem_op[rd_ptr_q]   : 2'b00;
    assign rsp_err    = rsp_valid && mem_err[rd_ptr_q];
    assign err_sticky = err_q;
    assign busy       = s1_q || s2_q || rsp_valid;

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a registered ALU model with a fault hook, and a scoreboard filled when
// commands are accepted and drained by a response monitor.
module tb_alu_cmd_issuer;
    localparam int RSP_DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [1:0] alu_opcode;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [4:0] alu_c;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_data;
    logic [1:0] rsp_op;
    logic       rsp_err;
    logic       err_sticky;
    logic       err_clr;
    logic       busy;

    typedef struct packed {
        logic [1:0] op;
        logic [4:0] data;
        logic       err;
    } rsp_t;

    rsp_t sb[$];
    rsp_t mon_exp;
    int   checks = 0;
    int   errors = 0;
    int   pops   = 0;
    logic corrupt_en = 1'b0;

    alu_cmd_issuer #(.RSP_DEPTH(RSP_DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c      (alu_c),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_op     (rsp_op),
        .rsp_err    (rsp_err),
        .err_sticky (err_sticky),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_result(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] ea;
        logic [4:0] eb;
        ea = {a[3], a};
        eb = {b[3], b};
        case (op)
            2'b00:   return ea + eb;
            2'b01:   return ea - eb;
            2'b10:   return ~ea;
            default: return (b != 4'd0) ? 5'd1 : 5'd0;
        endcase
    endfunction

    function automatic logic is_corrupt(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        return corrupt_en && (op == 2'b00) && (a == 4'd3) && (b == 4'd2);
    endfunction

    // ALU model: registered result, reset together with the issuer; one operand set can be made to lie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) alu_c <= 5'b00000;
        else          alu_c <= ref_result(alu_opcode, alu_a, alu_b) ^
                               (is_corrupt(alu_opcode, alu_a, alu_b) ? 5'b00100 : 5'b00000);
    end

    // Response monitor: the pop happens on the following rising edge.
    always @(negedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got op=%0d data=%b err=%b, required no response", rsp_op, rsp_data, rsp_err);
            end else begin
                mon_exp = sb.pop_front();
                pops++;
                $display("rsp #%0d op=%0d data=%b err=%b", pops, rsp_op, rsp_data, rsp_err);
                if ({rsp_op, rsp_data, rsp_err} !== mon_exp) begin
                    errors++;
                    $display("FAIL rsp_order: got op=%0d data=%b err=%b, required op=%0d data=%b err=%b",
                             rsp_op, rsp_data, rsp_err, mon_exp.op, mon_exp.data, mon_exp.err);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                             input logic [4:0] exp_data, output bit accepted);
        rsp_t e;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        accepted  = (cmd_ready === 1'b1);
        if (accepted) begin
            e.op   = op;
            e.err  = is_corrupt(op, a, b);
            e.data = e.err ? (exp_data ^ 5'b00100) : exp_data;
            sb.push_back(e);
        end
        step();
    endtask

    task automatic wait_drain(output bit ok);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && n < 50) begin
            step();
            n++;
        end
        ok = (sb.size() == 0) && (busy === 1'b0) && (rsp_valid === 1'b0);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({alu_opcode, alu_a, alu_b, rsp_valid, rsp_err, err_sticky, busy, cmd_ready} !== 15'b000000000000001) begin
            errors++;
            $display("FAIL reset_state: got %b, required %b",
                     {alu_opcode, alu_a, alu_b, rsp_valid, rsp_err, err_sticky, busy, cmd_ready}, 15'b000000000000001);
        end
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        bit acc;
        bit ok;
        rsp_ready = 1'b0;
        drive_cmd(2'b00, 4'd7, 4'd7, 5'b01110, acc);
        cmd_valid = 1'b0;
        checks++;
        if (acc !== 1'b1) begin
            errors++;
            $display("FAIL add_accept: got cmd_ready=%b, required 1", acc);
        end
        checks++;
        if ({alu_opcode, alu_a, alu_b, rsp_valid, busy} !== {2'b00, 4'd7, 4'd7, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_alu_drive: got op=%0d a=%0d b=%0d rsp_valid=%b busy=%b, required 0 7 7 0 1",
                     alu_opcode, alu_a, alu_b, rsp_valid, busy);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b0 || alu_a !== 4'd7 || alu_b !== 4'd7) begin
            errors++;
            $display("FAIL add_e1: got rsp_valid=%b a=%0d b=%0d, required 0 7 7", rsp_valid, alu_a, alu_b);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_op, rsp_data, rsp_err} !== {1'b1, 2'b00, 5'b01110, 1'b0}) begin
            errors++;
            $display("FAIL add_e2: got valid=%b op=%0d data=%b err=%b, required 1 0 01110 0",
                     rsp_valid, rsp_op, rsp_data, rsp_err);
        end
        step();
        checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 5'b01110}) begin
            errors++;
            $display("FAIL add_hold: got valid=%b data=%b, required 1 01110", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || pops != 1) begin
            errors++;
            $display("FAIL add_drain: got pops=%0d busy=%b, required 1 0", pops, busy);
        end
    endtask

    task automatic test_ops_back_to_back();
        bit acc;
        bit ok;
        int n_acc;
        int p0;
        n_acc = 0;
        p0 = pops;
        rsp_ready = 1'b1;
        drive_cmd(2'b01, 4'b1000, 4'b0111, 5'b10001, acc); n_acc += int'(acc);
        drive_cmd(2'b10, 4'd5,    4'd0,    5'b11010, acc); n_acc += int'(acc);
        drive_cmd(2'b11, 4'd3,    4'd0,    5'b00000, acc); n_acc += int'(acc);
        drive_cmd(2'b11, 4'd0,    4'b1000, 5'b00001, acc); n_acc += int'(acc);
        drive_cmd(2'b00, 4'b1000, 4'b1000, 5'b10000, acc); n_acc += int'(acc);
        drive_cmd(2'b01, 4'd7,    4'b1000, 5'b01111, acc); n_acc += int'(acc);
        cmd_valid = 1'b0;
        checks++;
        if (n_acc != 6) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d, required 6", n_acc);
        end
        wait_drain(ok);
        checks++;
        if (!ok || pops - p0 != 6 || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got pops=%0d err_sticky=%b, required 6 0", pops - p0, err_sticky);
        end
    endtask

    task automatic test_backpressure();
        bit acc;
        bit ok;
        int n_acc;
        int p0;
        n_acc = 0;
        p0 = pops;
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_cmd(2'b00, 4'(i), 4'd1, ref_result(2'b00, 4'(i), 4'd1), acc);
            n_acc += int'(acc);
        end
        cmd_valid = 1'b0;
        checks++;
        if (n_acc != RSP_DEPTH || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: got %0d ready=%b, required %0d 0", n_acc, cmd_ready, RSP_DEPTH);
        end
        step();
        step();
        checks++;
        if ({rsp_valid, busy, cmd_ready, rsp_data} !== {1'b1, 1'b1, 1'b0, 5'b00001}) begin
            errors++;
            $display("FAIL bp_full: got valid=%b busy=%b ready=%b data=%b, required 1 1 0 00001",
                     rsp_valid, busy, cmd_ready, rsp_data);
        end
        rsp_ready = 1'b1;
        step();
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_return: got %b, required 1", cmd_ready);
        end
        wait_drain(ok);
        checks++;
        if (!ok || pops - p0 != RSP_DEPTH) begin
            errors++;
            $display("FAIL bp_drain: got pops=%0d, required %0d", pops - p0, RSP_DEPTH);
        end
    endtask

    task automatic test_full_throughput();
        bit acc;
        bit ok;
        int n_acc;
        int p0;
        int p1;
        p0 = pops;
        rsp_ready = 1'b0;
        for (int i = 0; i < RSP_DEPTH; i++) begin
            drive_cmd(2'b01, 4'(i), 4'(3 * i), ref_result(2'b01, 4'(i), 4'(3 * i)), acc);
        end
        cmd_valid = 1'b0;
        step();
        step();
        checks++;
        if (cmd_ready !== 1'b0 || rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL tp_full: got ready=%b valid=%b, required 0 1", cmd_ready, rsp_valid);
        end
        rsp_ready = 1'b1;
        n_acc = 0;
        p1 = pops;
        for (int i = 0; i < 12; i++) begin
            drive_cmd(2'(i), 4'(i), 4'(15 - i), ref_result(2'(i), 4'(i), 4'(15 - i)), acc);
            n_acc += int'(acc);
        end
        cmd_valid = 1'b0;
        checks++;
        if (n_acc != 11 || pops - p1 != 12) begin
            errors++;
            $display("FAIL tp_steady: got accepts=%0d pops=%0d, required 11 12", n_acc, pops - p1);
        end
        wait_drain(ok);
        checks++;
        if (!ok || pops - p0 != RSP_DEPTH + 11) begin
            errors++;
            $display("FAIL tp_drain: got pops=%0d, required %0d", pops - p0, RSP_DEPTH + 11);
        end
    endtask

    task automatic test_error();
        bit acc;
        bit ok;
        rsp_ready  = 1'b0;
        corrupt_en = 1'b1;
        drive_cmd(2'b00, 4'd1, 4'd1, 5'd2, acc);
        drive_cmd(2'b00, 4'd3, 4'd2, 5'd5, acc);
        drive_cmd(2'b00, 4'd2, 4'd2, 5'd4, acc);
        cmd_valid = 1'b0;
        step();
        step();
        checks++;
        if (err_sticky !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL err_set: got sticky=%b head_err=%b, required 1 0", err_sticky, rsp_err);
        end
        rsp_ready = 1'b1;
        wait_drain(ok);
        checks++;
        if (!ok || err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_hold: got sticky=%b drained=%b, required 1 1", err_sticky, ok);
        end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b, required 0", err_sticky);
        end
        err_clr = 1'b1;
        drive_cmd(2'b00, 4'd3, 4'd2, 5'd5, acc);
        cmd_valid = 1'b0;
        step();
        step();
        checks++;
        if (err_sticky !== 1'b1) begin
            errors++;
            $display("FAIL err_set_wins: got %b, required 1", err_sticky);
        end
        step();
        err_clr = 1'b0;
        checks++;
        if (err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_after: got %b, required 0", err_sticky);
        end
        wait_drain(ok);
        corrupt_en = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL err_drain: got busy=%b queued=%0d, required 0 0", busy, sb.size());
        end
    endtask

    task automatic test_reset_midstream();
        bit acc;
        bit seen;
        rsp_ready  = 1'b0;
        corrupt_en = 1'b1;
        drive_cmd(2'b00, 4'd3, 4'd2, 5'd5, acc);
        drive_cmd(2'b10, 4'd1, 4'd0, 5'b11110, acc);
        drive_cmd(2'b01, 4'd4, 4'd1, 5'd3, acc);
        cmd_valid = 1'b0;
        checks++;
        if ({err_sticky, rsp_valid, busy} !== 3'b111) begin
            errors++;
            $display("FAIL mid_pre: got sticky=%b valid=%b busy=%b, required 1 1 1", err_sticky, rsp_valid, busy);
        end
        reset_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if ({alu_opcode, alu_a, alu_b, rsp_valid, rsp_err, err_sticky, busy, cmd_ready} !== 15'b000000000000001) begin
            errors++;
            $display("FAIL mid_reset_state: got %b, required %b",
                     {alu_opcode, alu_a, alu_b, rsp_valid, rsp_err, err_sticky, busy, cmd_ready}, 15'b000000000000001);
        end
        step();
        step();
        reset_n    = 1'b1;
        corrupt_en = 1'b0;
        rsp_ready  = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_no_rsp: got activity after reset, required none");
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_a     = 4'd0;
        cmd_b     = 4'd0;
        rsp_ready = 1'b0;
        err_clr   = 1'b0;
        test_reset();
        test_add();
        test_ops_back_to_back();
        test_backpressure();
        test_full_throughput();
        test_error();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
